latch_write_arbiter: RTL

//  Shares one DW-bit D-latch bank among NREQ requesters. Round-robin grant, then

---
 rtl/latch_write_arbiter_if.sv | 26 ++
 rtl/latch_write_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/latch_write_arbiter_if.sv
// Bundle between the requesters and the latch write arbiter.
// The master side raises requests and supplies write data; the slave side drives the latch bank controls.
interface latch_write_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int GW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      latch_d;
    logic               latch_en;
    logic [GW-1:0]      grant_id;
    logic               busy;

    modport master (
        output req, wdata,
        input  ack, latch_d, latch_en, grant_id, busy
    );

    modport slave (
        input  req, wdata,
        output ack, latch_d, latch_en, grant_id, busy
    );
endinterface

// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter that shares one D-latch bank among NREQ requesters.
// Each write is sequenced as setup, then OPEN_CYC cycles with the enable high, then hold with an ack pulse.
module latch_write_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int OPEN_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    latch_write_arbiter_if.slave  bus
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_OPEN,
        S_CLOSE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [DW-1:0]   latch_d_q, latch_d_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] last_ack_q;
    logic            latch_en_q, latch_en_d;
    logic            busy_q, busy_d;

    logic [NREQ-1:0] req_eff;
    logic            found;
    logic [GW-1:0]   pick;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        latch_d_d  = latch_d_q;
        ack_d      = '0;
        found      = 1'b0;
        pick       = '0;

        // A requester acked on the previous edge may still be holding req for one cycle.
        req_eff = bus.req & ~last_ack_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_eff[(int'(ptr_q) + i) % NREQ]) begin
                found = 1'b1;
                pick  = GW'((int'(ptr_q) + i) % NREQ);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_id_d = pick;
                    latch_d_d  = bus.wdata[int'(pick)*DW +: DW];
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = CW'(OPEN_CYC - 1);
                state_d = S_OPEN;
            end
            S_OPEN: begin
                if (cnt_q == '0) begin
                    state_d           = S_CLOSE;
                    ack_d[grant_id_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CLOSE: begin
                ptr_d   = GW'((int'(grant_id_q) + 1) % NREQ);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Enable and busy are registered from the next state so they never glitch.
        latch_en_d = (state_d == S_OPEN);
        busy_d     = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            grant_id_q <= '0;
            latch_d_q  <= '0;
            ack_q      <= '0;
            last_ack_q <= '0;
            latch_en_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            latch_d_q  <= latch_d_d;
            ack_q      <= ack_d;
            last_ack_q <= ack_q;
            latch_en_q <= latch_en_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.latch_d  = latch_d_q;
    assign bus.latch_en = latch_en_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = busy_q;
endmodule
